// File: rtl/frame_pixel_server.sv
// frame_pixel_server
//
// Answers pixel-coordinate requests from a consumer out of a one-entry
// pixel cache, fetching from a byte-wide frame buffer on a miss.
//
// Handshakes:
//   Consumer side: the consumer holds req_x/req_y/req_en and samples pixel on
//     any clk edge where waitrequest=0. waitrequest is purely combinational
//     from the current request and the cache registers.
//   Memory side: a read command is accepted on a clk edge where mem_read=1 and
//     mem_waitrequest=0. Command signals are held stable while stalled. Read
//     data returns later, qualified by mem_readdatavalid. Only one read is
//     ever outstanding.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_en, req_x, req_y  consumer request (coordinates are signed)
//   pixel, waitrequest    consumer response
//   mem_address, mem_read, mem_waitrequest,
//   mem_readdata, mem_readdatavalid
//                         frame buffer read port
//   fetch_count           number of accepted memory reads since reset (wraps)
//   state_dbg             current FSM state, for observation only

module frame_pixel_server #(
    parameter int ROW_NUM   = 480,
    parameter int COL_NUM   = 640,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic [10:0]       req_x,
    input  logic [10:0]       req_y,
    output logic [7:0]        pixel,
    output logic              waitrequest,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic              mem_waitrequest,
    input  logic [7:0]        mem_readdata,
    input  logic              mem_readdatavalid,
    output logic [31:0]       fetch_count,
    output logic [1:0]        state_dbg
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DATA = 2'd2;

    logic [1:0]        state_q,       state_d;
    logic [10:0]       pend_x_q,      pend_x_d;
    logic [10:0]       pend_y_q,      pend_y_d;
    logic [10:0]       cache_x_q,     cache_x_d;
    logic [10:0]       cache_y_q,     cache_y_d;
    logic [7:0]        cache_data_q,  cache_data_d;
    logic              cache_valid_q, cache_valid_d;
    logic              mem_read_q,    mem_read_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [31:0]       fetch_count_q, fetch_count_d;

    // Sign-extended coordinates so the range test works on negative inputs.
    logic signed [31:0] req_x_s;
    logic signed [31:0] req_y_s;
    logic               out_of_range;
    logic               cache_match;
    logic               hit;
    logic [ADDR_W-1:0]  req_addr;

    assign req_x_s = 32'(signed'(req_x));
    assign req_y_s = 32'(signed'(req_y));

    assign out_of_range = (req_x_s < 0) || (req_x_s >= COL_NUM) ||
                          (req_y_s < 0) || (req_y_s >= ROW_NUM);

    assign cache_match = cache_valid_q && (req_x == cache_x_q) && (req_y == cache_y_q);

    // Disabled and off-frame requests never need memory: they answer 0 at once.
    assign hit         = !req_en || out_of_range || cache_match;
    assign waitrequest = !hit;
    assign pixel       = (req_en && !out_of_range) ? cache_data_q : 8'd0;

    // Only evaluated on a miss, where the coordinates are known in range and
    // therefore non-negative, so unsigned arithmetic is exact.
    assign req_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(req_y) * ADDR_W'(COL_NUM) + ADDR_W'(req_x);

    always_comb begin
        state_d       = state_q;
        pend_x_d      = pend_x_q;
        pend_y_d      = pend_y_q;
        cache_x_d     = cache_x_q;
        cache_y_d     = cache_y_q;
        cache_data_d  = cache_data_q;
        cache_valid_d = cache_valid_q;
        mem_read_d    = mem_read_q;
        mem_address_d = mem_address_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            IDLE: begin
                if (!hit) begin
                    pend_x_d      = req_x;
                    pend_y_d      = req_y;
                    mem_address_d = req_addr;
                    mem_read_d    = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_waitrequest) begin
                    mem_read_d    = 1'b0;
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                // The fill always targets the coordinate that was fetched,
                // even if the consumer has since moved on.
                if (mem_readdatavalid) begin
                    cache_data_d  = mem_readdata;
                    cache_x_d     = pend_x_q;
                    cache_y_d     = pend_y_q;
                    cache_valid_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                mem_read_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pend_x_q      <= '0;
            pend_y_q      <= '0;
            cache_x_q     <= '0;
            cache_y_q     <= '0;
            cache_data_q  <= '0;
            cache_valid_q <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_x_q      <= pend_x_d;
            pend_y_q      <= pend_y_d;
            cache_x_q     <= cache_x_d;
            cache_y_q     <= cache_y_d;
            cache_data_q  <= cache_data_d;
            cache_valid_q <= cache_valid_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;
    assign fetch_count = fetch_count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_frame_pixel_server.sv
// Testbench for frame_pixel_server: combinational response table plus
// cycle-accurate directed sequences for fetch, stall, retarget and reset.

module tb_frame_pixel_server;

    localparam int ADDR_W = 20;

    logic              clk;
    logic              clk_run;
    logic              rst;
    logic              req_en;
    logic [10:0]       req_x;
    logic [10:0]       req_y;
    logic [7:0]        pixel;
    logic              waitrequest;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_waitrequest;
    logic [7:0]        mem_readdata;
    logic              mem_readdatavalid;
    logic [31:0]       fetch_count;
    logic [1:0]        state_dbg;

    int n_checks;
    int n_fails;

    frame_pixel_server #(
        .ROW_NUM   (480),
        .COL_NUM   (640),
        .BASE_ADDR (0),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_en            (req_en),
        .req_x             (req_x),
        .req_y             (req_y),
        .pixel             (pixel),
        .waitrequest       (waitrequest),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .fetch_count       (fetch_count),
        .state_dbg         (state_dbg)
    );

    // ---------------- clock / reset ----------------
    // The clock can be parked so the combinational table runs with no edges.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Advance to just after the next rising edge; a cycle's inputs are then
    // applied and its outputs checked before the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic en, input logic [10:0] x, input logic [10:0] y);
        req_en = en;
        req_x  = x;
        req_y  = y;
    endtask

    task automatic drive_mem(input logic stall, input logic rdv, input logic [7:0] data);
        mem_waitrequest   = stall;
        mem_readdatavalid = rdv;
        mem_readdata      = data;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- combinational table ----------------
    typedef struct {
        logic        en;
        logic [10:0] x;
        logic [10:0] y;
        logic        exp_wait;
        logic [7:0]  exp_pix;
    } vec_t;

    vec_t vecs[12];

    initial begin
        n_checks = 0;
        n_fails  = 0;
        clk_run  = 1'b1;
        rst      = 1'b1;
        drive_req(1'b0, 11'd0, 11'd0);
        drive_mem(1'b0, 1'b0, 8'h00);

        // Cache will hold (3,2) = 0x5A when the table runs.
        vecs[0]  = '{1'b1, 11'd3,    11'd2,    1'b0, 8'h5A};
        vecs[1]  = '{1'b1, 11'h7FF,  11'd0,    1'b0, 8'h00}; // x = -1
        vecs[2]  = '{1'b1, 11'd640,  11'd5,    1'b0, 8'h00};
        vecs[3]  = '{1'b1, 11'd0,    11'd480,  1'b0, 8'h00};
        vecs[4]  = '{1'b1, 11'd639,  11'd479,  1'b1, 8'h5A}; // last in-range pixel
        vecs[5]  = '{1'b1, 11'd4,    11'd2,    1'b1, 8'h5A};
        vecs[6]  = '{1'b1, 11'd3,    11'd3,    1'b1, 8'h5A};
        vecs[7]  = '{1'b0, 11'd700,  11'd700,  1'b0, 8'h00};
        vecs[8]  = '{1'b0, 11'd3,    11'd2,    1'b0, 8'h00};
        vecs[9]  = '{1'b1, 11'd0,    11'h7FF,  1'b0, 8'h00}; // y = -1
        vecs[10] = '{1'b1, 11'h400,  11'd0,    1'b0, 8'h00}; // x = -1024
        vecs[11] = '{1'b1, 11'd0,    11'd0,    1'b1, 8'h5A};

        // ---- reset ----
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_mem_read",    32'(mem_read),    32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_fetch_count", fetch_count,      32'd0);
        chk("rst_wait",        32'(waitrequest), 32'd0);
        chk("rst_pixel",       32'(pixel),       32'd0);

        // ---- miss on (3,2), latency 2, no stall ----
        drive_req(1'b1, 11'd3, 11'd2);           // cycle 0
        settle();
        chk("a0_wait",     32'(waitrequest), 32'd1);
        chk("a0_mem_read", 32'(mem_read),    32'd0);
        tick();                                  // cycle 1
        settle();
        chk("a1_mem_read", 32'(mem_read),    32'd1);
        chk("a1_addr",     32'(mem_address), 32'd1283);
        chk("a1_wait",     32'(waitrequest), 32'd1);
        tick();                                  // cycle 2
        settle();
        chk("a2_mem_read", 32'(mem_read),    32'd0);
        chk("a2_fetch",    fetch_count,      32'd1);
        chk("a2_wait",     32'(waitrequest), 32'd1);
        tick();                                  // cycle 3
        drive_mem(1'b0, 1'b1, 8'h5A);
        settle();
        chk("a3_wait",     32'(waitrequest), 32'd1);
        tick();                                  // cycle 4
        drive_mem(1'b0, 1'b0, 8'h00);
        settle();
        chk("a4_wait",     32'(waitrequest), 32'd0);
        chk("a4_pixel",    32'(pixel),       32'h5A);
        chk("a4_fetch",    fetch_count,      32'd1);

        // ---- repeat hit for 5 cycles; stray readdatavalid in IDLE ignored ----
        for (int i = 0; i < 5; i++) begin
            tick();
            drive_mem(1'b0, (i == 1), 8'hFF);
            settle();
            chk("hold_wait",     32'(waitrequest), 32'd0);
            chk("hold_mem_read", 32'(mem_read),    32'd0);
            chk("hold_pixel",    32'(pixel),       32'h5A);
        end
        drive_mem(1'b0, 1'b0, 8'h00);
        chk("hold_fetch", fetch_count, 32'd1);

        // ---- combinational table with the clock parked ----
        clk_run = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive_req(vecs[i].en, vecs[i].x, vecs[i].y);
            settle();
            chk($sformatf("tbl%0d_wait", i),     32'(waitrequest), 32'(vecs[i].exp_wait));
            chk($sformatf("tbl%0d_pixel", i),    32'(pixel),       32'(vecs[i].exp_pix));
            chk($sformatf("tbl%0d_mem_read", i), 32'(mem_read),    32'd0);
        end
        drive_req(1'b0, 11'd0, 11'd0);
        settle();
        clk_run = 1'b1;
        tick();

        // ---- out-of-range requests across clock edges: no fetch ----
        drive_req(1'b1, 11'h7FF, 11'd0);
        tick();
        drive_req(1'b1, 11'd640, 11'd5);
        tick();
        drive_req(1'b1, 11'd0, 11'd480);
        settle();
        chk("oor_wait",     32'(waitrequest), 32'd0);
        chk("oor_pixel",    32'(pixel),       32'd0);
        tick();
        settle();
        chk("oor_mem_read", 32'(mem_read),    32'd0);
        chk("oor_fetch",    fetch_count,      32'd1);

        // ---- miss with 3 stall cycles at (639,479) ----
        drive_req(1'b1, 11'd639, 11'd479);       // cycle 0
        drive_mem(1'b1, 1'b0, 8'h00);
        settle();
        chk("s0_wait", 32'(waitrequest), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            drive_mem((c < 4), 1'b0, 8'h00);
            settle();
            chk($sformatf("s%0d_mem_read", c), 32'(mem_read),    32'd1);
            chk($sformatf("s%0d_addr", c),     32'(mem_address), 32'd307199);
            chk($sformatf("s%0d_fetch", c),    fetch_count,      32'd1);
        end
        tick();                                  // cycle 5: WAIT_DATA
        drive_mem(1'b0, 1'b1, 8'h33);
        settle();
        chk("s5_mem_read", 32'(mem_read), 32'd0);
        chk("s5_fetch",    fetch_count,   32'd2);
        tick();                                  // cycle 6
        drive_mem(1'b0, 1'b0, 8'h00);
        settle();
        chk("s6_wait",  32'(waitrequest), 32'd0);
        chk("s6_pixel", 32'(pixel),       32'h33);

        // ---- retarget (10,10)->(11,10) during WAIT_DATA, plus req_en drop ----
        drive_req(1'b1, 11'd10, 11'd10);         // cycle 0
        tick();                                  // cycle 1
        settle();
        chk("r1_addr", 32'(mem_address), 32'd6410);
        tick();                                  // cycle 2: WAIT_DATA
        drive_req(1'b0, 11'd11, 11'd10);
        settle();
        chk("r2_off_wait",  32'(waitrequest), 32'd0);
        chk("r2_off_pixel", 32'(pixel),       32'd0);
        drive_req(1'b1, 11'd11, 11'd10);
        settle();
        chk("r2_wait",  32'(waitrequest), 32'd1);
        chk("r2_fetch", fetch_count,      32'd3);
        tick();                                  // cycle 3
        drive_mem(1'b0, 1'b1, 8'h77);
        settle();
        tick();                                  // cycle 4: cache = (10,10)
        drive_mem(1'b0, 1'b0, 8'h00);
        settle();
        chk("r4_wait",     32'(waitrequest), 32'd1);
        chk("r4_mem_read", 32'(mem_read),    32'd0);
        drive_req(1'b1, 11'd10, 11'd10);
        settle();
        chk("r4_old_wait",  32'(waitrequest), 32'd0);
        chk("r4_old_pixel", 32'(pixel),       32'h77);
        drive_req(1'b1, 11'd11, 11'd10);
        tick();                                  // cycle 5
        settle();
        chk("r5_mem_read", 32'(mem_read),    32'd1);
        chk("r5_addr",     32'(mem_address), 32'd6411);
        tick();                                  // cycle 6
        drive_mem(1'b0, 1'b1, 8'h88);
        settle();
        chk("r6_fetch", fetch_count, 32'd4);
        tick();                                  // cycle 7
        drive_mem(1'b0, 1'b0, 8'h00);
        settle();
        chk("r7_wait",  32'(waitrequest), 32'd0);
        chk("r7_pixel", 32'(pixel),       32'h88);

        // ---- reset during WAIT_DATA, late readdatavalid discarded ----
        drive_req(1'b1, 11'd20, 11'd30);         // cycle 0
        tick();                                  // cycle 1
        settle();
        chk("x1_addr", 32'(mem_address), 32'd19220);
        tick();                                  // cycle 2: WAIT_DATA
        rst = 1'b1;
        settle();
        tick();                                  // cycle 3: reset applied
        rst = 1'b0;
        drive_req(1'b1, 11'd0, 11'd0);
        drive_mem(1'b0, 1'b1, 8'h99);
        settle();
        chk("x3_fetch",    fetch_count,      32'd0);
        chk("x3_mem_read", 32'(mem_read),    32'd0);
        chk("x3_state",    32'(state_dbg),   32'd0);
        chk("x3_wait",     32'(waitrequest), 32'd1);
        chk("x3_pixel",    32'(pixel),       32'd0);
        tick();                                  // cycle 4
        drive_mem(1'b0, 1'b0, 8'h00);
        settle();
        chk("x4_wait",     32'(waitrequest), 32'd1);
        chk("x4_mem_read", 32'(mem_read),    32'd1);
        chk("x4_addr",     32'(mem_address), 32'd0);
        tick();                                  // cycle 5
        drive_mem(1'b0, 1'b1, 8'h11);
        settle();
        chk("x5_fetch", fetch_count, 32'd1);
        tick();                                  // cycle 6
        drive_mem(1'b0, 1'b0, 8'h00);
        settle();
        chk("x6_wait",  32'(waitrequest), 32'd0);
        chk("x6_pixel", 32'(pixel),       32'h11);

        // ---- final report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/frame_pixel_server.md
FRAME_PIXEL_SERVER -- requirements
Module: frame_pixel_server

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ROW_NUM, 480, frame rows.
- COL_NUM, 640, frame columns.
- BASE_ADDR, 0, byte address of pixel (0,0) in the frame buffer.
- ADDR_W, 20, memory address width.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- req_en, in, 1, consumer enabled; requests are served only when high.
- req_x, in, 11, requested column, signed two's complement.
- req_y, in, 11, requested row, signed two's complement.
- pixel, out, 8, pixel value for (req_x, req_y); valid when waitrequest is 0.
- waitrequest, out, 1, high while the requested pixel is not yet available.
- mem_address, out, ADDR_W, read address to the frame buffer.
- mem_read, out, 1, read strobe.
- mem_waitrequest, in, 1, memory stall; the command is accepted when mem_read=1 and mem_waitrequest=0.
- mem_readdata, in, 8, read data.
- mem_readdatavalid, in, 1, mem_readdata is valid this cycle.
- fetch_count, out, 32, number of memory reads accepted since reset.

Function
REQ-003 The block SHALL be the responder for a pixel-coordinate request interface: the consumer drives coordinates and samples pixel on any clk edge where waitrequest=0.
REQ-004 out_of_range SHALL be 1 when req_x<0, req_x>=COL_NUM, req_y<0, or req_y>=ROW_NUM, using signed compares.
REQ-005 The block SHALL hold a one-entry cache of cache_x, cache_y, cache_data and cache_valid.
REQ-006 hit SHALL be 1 when req_en=0, or out_of_range=1, or (cache_valid=1 and req_x==cache_x and req_y==cache_y).
REQ-007 waitrequest SHALL equal NOT hit and SHALL be combinational from the current inputs and registers.
REQ-008 pixel SHALL be 0 when req_en=0 or out_of_range=1, and SHALL equal cache_data otherwise.
REQ-009 FSM states SHALL be IDLE, ISSUE and WAIT_DATA.
REQ-010 IDLE: if hit=0, the block SHALL latch pend_x=req_x and pend_y=req_y, register mem_address = BASE_ADDR + pend_y*COL_NUM + pend_x (ADDR_W bits, unsigned), set mem_read=1, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-011 ISSUE: mem_read and mem_address SHALL be held stable while mem_waitrequest=1.
REQ-012 ISSUE: on mem_waitrequest=0, the block SHALL clear mem_read, increment fetch_count, and go to WAIT_DATA.
REQ-013 WAIT_DATA: on mem_readdatavalid=1, the block SHALL load cache_data=mem_readdata, cache_x=pend_x, cache_y=pend_y and cache_valid=1, then go to IDLE.
REQ-014 mem_readdatavalid SHALL be ignored outside WAIT_DATA.
REQ-015 Only one read SHALL be outstanding at a time.
REQ-016 A change of req_x/req_y during ISSUE or WAIT_DATA SHALL NOT abort the fetch: it completes and fills the cache with pend_x/pend_y, and the hit test then applies to the new request.
REQ-017 A req_en drop mid-fetch SHALL NOT abort the fetch; waitrequest=0 and pixel=0 while req_en=0.
REQ-018 Miss latency: with mem_waitrequest=0 and read latency L cycles, the miss is seen in IDLE at cycle 0, mem_read=1 in cycle 1, readdatavalid arrives in cycle 1+L, and waitrequest=0 in cycle 2+L.
REQ-019 A repeated request for the cached coordinate SHALL return waitrequest=0 in the same cycle with no memory access.
REQ-020 fetch_count SHALL wrap modulo 2^32.

Reset
REQ-021 On rst=1 at a clk edge: state SHALL be IDLE, mem_read=0, mem_address=0, cache_valid=0, cache_data=0, cache_x=0, cache_y=0, pend_x=0, pend_y=0, fetch_count=0.
REQ-022 Reset SHALL take effect mid-fetch; a readdatavalid returning after reset SHALL be discarded (REQ-014).
REQ-023 After reset, a request for (0,0) with req_en=1 SHALL miss and trigger a fetch.

Verification
REQ-024 Defaults, req_en=1, (x,y)=(3,2), mem latency 2, no stall -> mem_address=1283 in cycle 1, waitrequest=0 with pixel=readdata in cycle 4, fetch_count=1.
REQ-025 Same (3,2) held 5 more cycles -> waitrequest=0 throughout, mem_read stays 0, fetch_count remains 1.
REQ-026 Requests (-1,0), (640,5), (0,480) -> waitrequest=0 and pixel=0 in the same cycle, no mem_read.
REQ-027 Miss with mem_waitrequest=1 for 3 cycles -> mem_read and mem_address stable for 4 cycles, fetch_count increments once.
REQ-028 Request changes from (10,10) to (11,10) during WAIT_DATA -> cache fills (10,10), then a second fetch at address 6411.
REQ-029 rst during WAIT_DATA, readdatavalid=1 one cycle later -> cache_valid stays 0, waitrequest=1 for non-trivial in-range requests.
